// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter state encoding, command bytes and frame builder.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RTS       = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    STOP      = 3'd4,
    ACK       = 3'd5,
    WAIT_IDLE = 3'd6
  } state_t;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] ACK_BYTE    = 8'hFA;

  // Nine-bit shift word {odd parity, data}; data LSB leaves first.
  function automatic logic [8:0] frame_word(input logic [7:0] data);
    return {~^data, data};
  endfunction

endpackage

// File: rtl/ps2_edge_filter.sv
// PS/2 clock conditioner: 2-FF synchronizer, FILT_LEN-sample level filter, falling-edge tick.
module ps2_edge_filter #(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic level,
  output logic fall_tick
);

  localparam int CW = $clog2(FILT_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Bring the pad level into the clk domain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], line_in};
    end
  end

  // Accept a new level only after FILT_LEN consecutive differing samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level     <= 1'b1;
      cnt       <= {CW{1'b0}};
      fall_tick <= 1'b0;
    end else if (sync[1] == level) begin
      cnt       <= {CW{1'b0}};
      fall_tick <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      level     <= sync[1];
      cnt       <= {CW{1'b0}};
      fall_tick <= level;
    end else begin
      cnt       <= cnt + CNT_ONE;
      fall_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (request-to-send, 11-bit frame, ACK check).
// Optional device-clock watchdog enabled by defining PS2_HOST_TX_TIMEOUT_EN.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYC = 5000,
  parameter int FILT_LEN    = 4,
  parameter int TIMEOUT_CYC = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       tx_ack_err
);

  localparam int INH_W = $clog2(INHIBIT_CYC + 1);
  localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INHIBIT_CYC - 1);
  localparam logic [INH_W-1:0] INH_ONE  = INH_W'(1);
  localparam logic [INH_W-1:0] INH_ZERO = {INH_W{1'b0}};

  state_t           state, state_next;
  logic [8:0]       shift, shift_next;
  logic [3:0]       bit_cnt, bit_cnt_next;
  logic [INH_W-1:0] inh_cnt, inh_next;
  logic             c_oe_next, d_oe_next, done_next, err_next;
  logic             c_level, fall_tick, timeout;
  logic [1:0]       d_sync;

  ps2_edge_filter #(.FILT_LEN(FILT_LEN)) u_clk_filter (
    .clk      (clk),
    .rst      (rst),
    .line_in  (ps2c_in),
    .level    (c_level),
    .fall_tick(fall_tick)
  );

  // Data line only needs synchronizing: it is sampled on filtered clock edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_sync <= 2'b11;
    end else begin
      d_sync <= {d_sync[0], ps2d_in};
    end
  end

`ifdef PS2_HOST_TX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [WD_W-1:0] WD_ONE   = WD_W'(1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_active;

  assign wd_active = (state inside {START, DATA, STOP, ACK, WAIT_IDLE});
  // Done already pending means the abort is in flight; do not fire twice.
  assign timeout   = wd_active && !tx_done_tick && !fall_tick && (wd_cnt == WD_LIMIT);

  // Watchdog restarts on entry to START and on every device clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt <= {WD_W{1'b0}};
    end else if ((state == RTS) || fall_tick) begin
      wd_cnt <= {WD_W{1'b0}};
    end else if (wd_active) begin
      wd_cnt <= wd_cnt + WD_ONE;
    end else begin
      wd_cnt <= {WD_W{1'b0}};
    end
  end
`else
  assign timeout = 1'b0;
  if (TIMEOUT_CYC > 0) begin : g_no_watchdog
  end
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_next   = state;
    shift_next   = shift;
    bit_cnt_next = bit_cnt;
    inh_next     = inh_cnt;
    c_oe_next    = ps2c_oe;
    d_oe_next    = ps2d_oe;
    done_next    = 1'b0;
    err_next     = tx_ack_err;
    if (timeout) begin
      // WAIT_IDLE with done pending returns to IDLE next cycle.
      c_oe_next  = 1'b0;
      d_oe_next  = 1'b0;
      err_next   = 1'b1;
      done_next  = 1'b1;
      state_next = WAIT_IDLE;
    end else begin
      case (state)
        IDLE: begin
          c_oe_next = 1'b0;
          d_oe_next = 1'b0;
          if (wr_ps2) begin
            shift_next = frame_word(din);
            err_next   = 1'b0;
            inh_next   = INH_LOAD;
            c_oe_next  = 1'b1;
            state_next = RTS;
          end else begin
            state_next = IDLE;
          end
        end
        RTS: begin
          if (inh_cnt == INH_ZERO) begin
            c_oe_next  = 1'b0;
            d_oe_next  = 1'b1;
            state_next = START;
          end else begin
            inh_next  = inh_cnt - INH_ONE;
            c_oe_next = 1'b1;
            // Pull data low during the last inhibit cycle so the start bit meets the clock release.
            d_oe_next = (inh_cnt == INH_ONE);
          end
        end
        START: begin
          c_oe_next = 1'b0;
          if (fall_tick) begin
            d_oe_next    = ~shift[0];
            shift_next   = {1'b0, shift[8:1]};
            bit_cnt_next = 4'd8;
            state_next   = DATA;
          end else begin
            d_oe_next = 1'b1;
          end
        end
        DATA: begin
          if (fall_tick) begin
            if (bit_cnt == 4'd0) begin
              d_oe_next  = 1'b0;
              state_next = STOP;
            end else begin
              d_oe_next    = ~shift[0];
              shift_next   = {1'b0, shift[8:1]};
              bit_cnt_next = bit_cnt - 4'd1;
            end
          end else begin
            state_next = DATA;
          end
        end
        STOP: begin
          if (fall_tick) begin
            state_next = ACK;
          end else begin
            state_next = STOP;
          end
        end
        ACK: begin
          if (fall_tick) begin
            err_next   = d_sync[1];
            state_next = WAIT_IDLE;
          end else begin
            state_next = ACK;
          end
        end
        WAIT_IDLE: begin
          c_oe_next = 1'b0;
          d_oe_next = 1'b0;
          // Done pulses while still here, so a same-cycle wr_ps2 is ignored.
          if (tx_done_tick) begin
            state_next = IDLE;
          end else if (c_level && d_sync[1]) begin
            done_next = 1'b1;
          end else begin
            done_next = 1'b0;
          end
        end
        default: begin
          c_oe_next  = 1'b0;
          d_oe_next  = 1'b0;
          state_next = IDLE;
        end
      endcase
    end
  end

  // State and registered outputs; reset releases both lines immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      shift        <= 9'd0;
      bit_cnt      <= 4'd0;
      inh_cnt      <= INH_ZERO;
      ps2c_oe      <= 1'b0;
      ps2d_oe      <= 1'b0;
      tx_idle      <= 1'b1;
      tx_done_tick <= 1'b0;
      tx_ack_err   <= 1'b0;
    end else begin
      state        <= state_next;
      shift        <= shift_next;
      bit_cnt      <= bit_cnt_next;
      inh_cnt      <= inh_next;
      ps2c_oe      <= c_oe_next;
      ps2d_oe      <= d_oe_next;
      tx_idle      <= (state_next == IDLE);
      tx_done_tick <= done_next;
      tx_ack_err   <= err_next;
    end
  end

endmodule
